// File: rtl/player_physics_pkg.sv
// player_physics_pkg: air-state encoding, default physics constants and the
// clamped-add helper shared by the player physics block and its jump helper.
package player_physics_pkg;

    typedef enum logic [1:0] {
        AIR_GROUND = 2'b00,
        AIR_RISE   = 2'b01,
        AIR_FALL   = 2'b10
    } air_state_t;

    localparam int DEF_COORD_W        = 10;
    localparam int DEF_VEL_W          = 8;
    localparam int DEF_SCREEN_W       = 640;
    localparam int DEF_SCREEN_H       = 480;
    localparam int DEF_PLAYER_W       = 16;
    localparam int DEF_PLAYER_H       = 16;
    localparam int DEF_H_SPEED        = 3;
    localparam int DEF_GRAVITY        = 1;
    localparam int DEF_JUMP_VEL       = -11;
    localparam int DEF_JUMP_CUT_VEL   = -4;
    localparam int DEF_MAX_FALL_VEL   = 8;
    localparam int DEF_JUMP_BUF_TICKS = 3;
    localparam int DEF_START_X        = 20;
    localparam int DEF_START_Y        = 344;
    localparam int COYOTE_TICKS       = 4;

    // Add a signed delta to a coordinate and clamp the result to [0, hi].
    function automatic int sat_add(input int base, input int delta, input int hi);
        int sum;
        sum = base + delta;
        if (sum < 0) begin
            sum = 0;
        end else if (sum > hi) begin
            sum = hi;
        end
        return sum;
    endfunction

endpackage

// File: rtl/player_physics_param_jump_assist.sv
// jump_assist: jump button edge detect, jump buffer and (with COYOTE_TIME_EN)
// the coyote grace counter. Produces jump_req / can_jump for the physics FSM.
// Macro: COYOTE_TIME_EN enables the coyote counter.
module jump_assist
    import player_physics_pkg::*;
#(
    parameter int BUF_TICKS = DEF_JUMP_BUF_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic game_tick,
    input  logic freeze,
    input  logic reset_player,
    input  logic jump,
    input  logic on_ground,
    input  logic coy_load,
    input  logic in_fall,
    input  logic launch,
    output logic jump_req,
    output logic can_jump
);

    localparam int CNT_MAX = (BUF_TICKS > COYOTE_TICKS) ? BUF_TICKS : COYOTE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             jump_prev;
    logic [CNT_W-1:0] buf_cnt;
    logic             press;
    logic             step;

    assign step     = game_tick & ~freeze & ~reset_player;
    assign press    = jump & ~jump_prev;
    assign jump_req = press | (buf_cnt != '0);

    // Edge detect on the tick-sampled button and the jump buffer countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_prev <= 1'b0;
            buf_cnt   <= '0;
        end else if (game_tick && reset_player) begin
            // A held button across a teleport must not count as a fresh press.
            jump_prev <= jump;
            buf_cnt   <= '0;
        end else if (step) begin
            jump_prev <= jump;
            if (launch) begin
                buf_cnt <= '0;
            end else if (press) begin
                buf_cnt <= CNT_W'(BUF_TICKS);
            end else if (buf_cnt != '0) begin
                buf_cnt <= buf_cnt - CNT_W'(1);
            end
        end
    end

`ifdef COYOTE_TIME_EN
    logic [CNT_W-1:0] coy_cnt;

    // Grace window after walking off a ledge; cleared outside of FALL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coy_cnt <= '0;
        end else if (game_tick && reset_player) begin
            coy_cnt <= '0;
        end else if (step) begin
            if (launch) begin
                coy_cnt <= '0;
            end else if (coy_load) begin
                coy_cnt <= CNT_W'(COYOTE_TICKS);
            end else if (!in_fall) begin
                coy_cnt <= '0;
            end else if (coy_cnt != '0) begin
                coy_cnt <= coy_cnt - CNT_W'(1);
            end
        end
    end

    assign can_jump = on_ground | (coy_cnt != '0);
`else
    logic unused_coy;
    assign unused_coy = coy_load ^ in_fall;
    assign can_jump   = on_ground;
`endif

endmodule

// File: rtl/player_physics_param.sv
// player_physics_param: per-tick walk / gravity / jump physics for one sprite
// with jump buffering, variable jump height and a GROUND/RISE/FALL air FSM.
// Macro: COYOTE_TIME_EN allows jumping for a few ticks after leaving ground.
module player_physics_param
    import player_physics_pkg::*;
#(
    parameter int COORD_W        = DEF_COORD_W,
    parameter int VEL_W          = DEF_VEL_W,
    parameter int SCREEN_W       = DEF_SCREEN_W,
    parameter int SCREEN_H       = DEF_SCREEN_H,
    parameter int PLAYER_W       = DEF_PLAYER_W,
    parameter int PLAYER_H       = DEF_PLAYER_H,
    parameter int H_SPEED        = DEF_H_SPEED,
    parameter int GRAVITY        = DEF_GRAVITY,
    parameter int JUMP_VEL       = DEF_JUMP_VEL,
    parameter int JUMP_CUT_VEL   = DEF_JUMP_CUT_VEL,
    parameter int MAX_FALL_VEL   = DEF_MAX_FALL_VEL,
    parameter int JUMP_BUF_TICKS = DEF_JUMP_BUF_TICKS,
    parameter int START_X        = DEF_START_X,
    parameter int START_Y        = DEF_START_Y
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      game_tick,
    input  logic                      move_left,
    input  logic                      move_right,
    input  logic                      jump,
    input  logic                      on_ground,
    input  logic [COORD_W-1:0]        support_y,
    input  logic                      hit_ceiling,
    input  logic                      hit_left_wall,
    input  logic                      hit_right_wall,
    input  logic                      freeze,
    input  logic                      reset_player,
    input  logic [COORD_W-1:0]        reset_x,
    input  logic [COORD_W-1:0]        reset_y,
    output logic [COORD_W-1:0]        player_x,
    output logic [COORD_W-1:0]        player_y,
    output logic signed [VEL_W-1:0]   vel_y,
    output logic [1:0]                air_state,
    output logic                      jump_start_pulse,
    output logic                      jump_landed_pulse
);

    localparam int X_MAX = SCREEN_W - PLAYER_W;
    localparam int Y_MAX = SCREEN_H - PLAYER_H;

    air_state_t                state;
    air_state_t                state_n;
    logic [COORD_W-1:0]        x_n;
    logic [COORD_W-1:0]        y_n;
    logic signed [VEL_W-1:0]   vel_n;
    logic                      start_n;
    logic                      land_n;
    logic                      launch;
    logic                      coy_load;
    logic                      jump_req;
    logic                      can_jump;
    logic                      in_fall;
    int                        vel_calc;

    assign in_fall   = (state == AIR_FALL);
    assign air_state = state;

    jump_assist #(
        .BUF_TICKS (JUMP_BUF_TICKS)
    ) u_jump_assist (
        .clk          (clk),
        .rst          (rst),
        .game_tick    (game_tick),
        .freeze       (freeze),
        .reset_player (reset_player),
        .jump         (jump),
        .on_ground    (on_ground),
        .coy_load     (coy_load),
        .in_fall      (in_fall),
        .launch       (launch),
        .jump_req     (jump_req),
        .can_jump     (can_jump)
    );

    // Next-state and next-position logic; teleport beats freeze beats physics.
    always_comb begin
        x_n      = player_x;
        y_n      = player_y;
        vel_n    = vel_y;
        state_n  = state;
        start_n  = 1'b0;
        land_n   = 1'b0;
        launch   = 1'b0;
        coy_load = 1'b0;
        vel_calc = int'(vel_y);

        if (game_tick && reset_player) begin
            x_n     = reset_x;
            y_n     = reset_y;
            vel_n   = '0;
            state_n = AIR_GROUND;
        end else if (game_tick && !freeze) begin
            if (move_left && !move_right && !hit_left_wall) begin
                x_n = COORD_W'(sat_add(int'(player_x), -H_SPEED, X_MAX));
            end else if (move_right && !move_left && !hit_right_wall) begin
                x_n = COORD_W'(sat_add(int'(player_x), H_SPEED, X_MAX));
            end

            if (jump_req && can_jump) begin
                // Take-off wins over landing and ceiling handling this tick.
                launch  = 1'b1;
                start_n = 1'b1;
                vel_n   = VEL_W'(JUMP_VEL);
                y_n     = COORD_W'(sat_add(int'(player_y), JUMP_VEL, Y_MAX));
                state_n = AIR_RISE;
            end else begin
                case (state)
                    AIR_GROUND: begin
                        if (on_ground) begin
                            y_n   = COORD_W'(sat_add(int'(support_y), -PLAYER_H, Y_MAX));
                            vel_n = '0;
                        end else begin
                            state_n  = AIR_FALL;
                            coy_load = 1'b1;
                        end
                    end
                    AIR_RISE: begin
                        vel_calc = int'(vel_y) + GRAVITY;
                        if (!jump && vel_calc < JUMP_CUT_VEL) begin
                            vel_calc = JUMP_CUT_VEL;
                        end
                        if (hit_ceiling && int'(vel_y) < 0) begin
                            vel_n   = '0;
                            state_n = AIR_FALL;
                        end else begin
                            vel_n = VEL_W'(vel_calc);
                            y_n   = COORD_W'(sat_add(int'(player_y), vel_calc, Y_MAX));
                            if (vel_calc >= 0) begin
                                state_n = AIR_FALL;
                            end
                        end
                    end
                    AIR_FALL: begin
                        if (on_ground) begin
                            y_n     = COORD_W'(sat_add(int'(support_y), -PLAYER_H, Y_MAX));
                            vel_n   = '0;
                            state_n = AIR_GROUND;
                            land_n  = 1'b1;
                        end else begin
                            vel_calc = int'(vel_y) + GRAVITY;
                            if (vel_calc > MAX_FALL_VEL) begin
                                vel_calc = MAX_FALL_VEL;
                            end
                            vel_n = VEL_W'(vel_calc);
                            y_n   = COORD_W'(sat_add(int'(player_y), vel_calc, Y_MAX));
                        end
                    end
                    default: begin
                        state_n = AIR_GROUND;
                    end
                endcase
            end
        end
    end

    // State, position and pulse registers; pulses last a single clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= AIR_GROUND;
            player_x          <= COORD_W'(START_X);
            player_y          <= COORD_W'(START_Y);
            vel_y             <= '0;
            jump_start_pulse  <= 1'b0;
            jump_landed_pulse <= 1'b0;
        end else begin
            state             <= state_n;
            player_x          <= x_n;
            player_y          <= y_n;
            vel_y             <= vel_n;
            jump_start_pulse  <= start_n;
            jump_landed_pulse <= land_n;
        end
    end

endmodule

// File: tb/tb_player_physics_param.sv
// Scoreboard bench for player_physics_param: directed scenarios plus random
// ticks, checked against a tick-level behavioural model of the player.
`timescale 1ns/1ps
module tb_player_physics_param;

    localparam int FLOOR = 360;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              game_tick = 1'b0;
    logic              move_left = 1'b0;
    logic              move_right = 1'b0;
    logic              jump = 1'b0;
    logic              on_ground = 1'b0;
    logic [9:0]        support_y = 10'd360;
    logic              hit_ceiling = 1'b0;
    logic              hit_left_wall = 1'b0;
    logic              hit_right_wall = 1'b0;
    logic              freeze = 1'b0;
    logic              reset_player = 1'b0;
    logic [9:0]        reset_x = '0;
    logic [9:0]        reset_y = '0;
    logic [9:0]        player_x;
    logic [9:0]        player_y;
    logic signed [7:0] vel_y;
    logic [1:0]        air_state;
    logic              jump_start_pulse;
    logic              jump_landed_pulse;

    always #5 clk = ~clk;

    player_physics_param dut (
        .clk               (clk),
        .rst               (rst),
        .game_tick         (game_tick),
        .move_left         (move_left),
        .move_right        (move_right),
        .jump              (jump),
        .on_ground         (on_ground),
        .support_y         (support_y),
        .hit_ceiling       (hit_ceiling),
        .hit_left_wall     (hit_left_wall),
        .hit_right_wall    (hit_right_wall),
        .freeze            (freeze),
        .reset_player      (reset_player),
        .reset_x           (reset_x),
        .reset_y           (reset_y),
        .player_x          (player_x),
        .player_y          (player_y),
        .vel_y             (vel_y),
        .air_state         (air_state),
        .jump_start_pulse  (jump_start_pulse),
        .jump_landed_pulse (jump_landed_pulse)
    );

    typedef struct {
        bit l, r, j, og;
        int sy;
        bit ceil, lw, rw, frz, rp;
        int rx, ry;
    } stim_t;

    typedef struct {
        int x, y, vel, st;
        bit start, land;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int land_cnt = 0;
    int dut_min_y = 1000;
    bit coyote_on = 1'b0;

    // Model state: position, velocity, air phase (0 ground, 1 rising, 2 falling),
    // remaining buffered-jump ticks, remaining coyote ticks, last sampled button.
    int m_x, m_y, m_vel, m_st, m_buf, m_coy;
    bit m_prev;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic bit env_ground();
        return (m_y + 16 >= FLOOR);
    endfunction

    function automatic stim_t mk(input bit l, input bit r, input bit j, input bit og);
        stim_t s;
        s.l = l; s.r = r; s.j = j; s.og = og; s.sy = FLOOR;
        s.ceil = 0; s.lw = 0; s.rw = 0; s.frz = 0; s.rp = 0; s.rx = 0; s.ry = 0;
        return s;
    endfunction

    function automatic stim_t mk_tp(input int rx, input int ry);
        stim_t s;
        s = mk(0, 0, 0, 0);
        s.rp = 1; s.rx = rx; s.ry = ry;
        return s;
    endfunction

    task automatic model_reset();
        m_x = 20; m_y = 344; m_vel = 0; m_st = 0; m_buf = 0; m_coy = 0; m_prev = 0;
    endtask

    // One game tick of the player's rules; pushes the expected outputs.
    task automatic model_step(input stim_t s);
        exp_t e;
        bit press, want, able;
        int nv, dx;
        e.start = 0;
        e.land  = 0;
        if (s.rp) begin
            m_x = s.rx; m_y = s.ry; m_vel = 0; m_st = 0; m_buf = 0; m_coy = 0; m_prev = s.j;
        end else if (!s.frz) begin
            press  = s.j && !m_prev;
            m_prev = s.j;
            want   = press || (m_buf > 0);
            able   = s.og || (coyote_on && m_coy > 0);
            m_buf  = press ? 3 : (m_buf > 0 ? m_buf - 1 : 0);
            dx = 0;
            if (s.l && !s.r && !s.lw) dx = -3;
            else if (s.r && !s.l && !s.rw) dx = 3;
            m_x = clamp(m_x + dx, 624);
            if (want && able) begin
                m_vel = -11; m_y = clamp(m_y - 11, 464); m_st = 1;
                m_buf = 0; m_coy = 0; e.start = 1;
            end else if (m_st == 0) begin
                if (s.og) begin
                    m_y = clamp(s.sy - 16, 464); m_vel = 0; m_coy = 0;
                end else begin
                    m_st = 2;
                    if (coyote_on) m_coy = 4;
                end
            end else if (m_st == 1) begin
                m_coy = 0;
                nv = m_vel + 1;
                if (!s.j && nv < -4) nv = -4;
                if (s.ceil && m_vel < 0) begin
                    m_vel = 0; m_st = 2;
                end else begin
                    m_vel = nv; m_y = clamp(m_y + nv, 464);
                    if (nv >= 0) m_st = 2;
                end
            end else begin
                if (m_coy > 0) m_coy--;
                if (s.og) begin
                    m_st = 0; m_y = clamp(s.sy - 16, 464); m_vel = 0; e.land = 1;
                end else begin
                    m_vel = (m_vel + 1 > 8) ? 8 : m_vel + 1;
                    m_y = clamp(m_y + m_vel, 464);
                end
            end
        end
        e.x = m_x; e.y = m_y; e.vel = m_vel; e.st = m_st;
        sb_q.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        move_left      = s.l;
        move_right     = s.r;
        jump           = s.j;
        on_ground      = s.og;
        support_y      = 10'(s.sy);
        hit_ceiling    = s.ceil;
        hit_left_wall  = s.lw;
        hit_right_wall = s.rw;
        freeze         = s.frz;
        reset_player   = s.rp;
        reset_x        = 10'(s.rx);
        reset_y        = 10'(s.ry);
    endtask

    task automatic tick(input stim_t s, input int gap);
        @(negedge clk);
        apply(s);
        game_tick = 1'b1;
        model_step(s);
        @(negedge clk);
        game_tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: pops an expectation after every tick edge; pulses must be low otherwise.
    always @(posedge clk) begin
        if (game_tick && !rst) begin
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow actual=0 expected=1 t=%0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("player_x", int'(player_x), mon_e.x);
                check("player_y", int'(player_y), mon_e.y);
                check("vel_y", int'(vel_y), mon_e.vel);
                check("air_state", int'(air_state), mon_e.st);
                check("jump_start_pulse", int'(jump_start_pulse), int'(mon_e.start));
                check("jump_landed_pulse", int'(jump_landed_pulse), int'(mon_e.land));
            end
            if (jump_start_pulse) start_cnt++;
            if (jump_landed_pulse) land_cnt++;
            if (int'(player_y) < dut_min_y) dut_min_y = int'(player_y);
        end else begin
            #1;
            check("start_pulse_clear", int'(jump_start_pulse), 0);
            check("land_pulse_clear", int'(jump_landed_pulse), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        int s0, l0, apex_hold, apex_tap;
        bit jmp;
`ifdef COYOTE_TIME_EN
        coyote_on = 1'b1;
`endif
        model_reset();
        #12;
        check("rst_x", int'(player_x), 20);
        check("rst_y", int'(player_y), 344);
        check("rst_vel", int'(vel_y), 0);
        check("rst_state", int'(air_state), 0);
        @(negedge clk);
        rst = 1'b0;

        // Scenario 1: reset asserted mid-jump.
        tick(mk(0, 0, 0, env_ground()), 0);
        tick(mk(0, 0, 1, env_ground()), 0);
        tick(mk(0, 1, 1, env_ground()), 0);
        tick(mk(0, 1, 1, env_ground()), 0);
        @(negedge clk);
        s = mk(0, 1, 1, env_ground());
        apply(s);
        game_tick = 1'b1;
        model_step(s);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midjump_rst_x", int'(player_x), 20);
        check("midjump_rst_y", int'(player_y), 344);
        check("midjump_rst_vel", int'(vel_y), 0);
        check("midjump_rst_state", int'(air_state), 0);
        check("midjump_rst_start", int'(jump_start_pulse), 0);
        check("midjump_rst_land", int'(jump_landed_pulse), 0);
        @(negedge clk);
        game_tick = 1'b0;
        apply(mk(0, 0, 0, 1));
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Scenario 2: hold jump through a full arc.
        tick(mk(0, 0, 0, env_ground()), 1);
        s0 = start_cnt; l0 = land_cnt; dut_min_y = 1000;
        for (int i = 0; i < 32; i++) tick(mk(0, 0, 1, env_ground()), 0);
        for (int i = 0; i < 3; i++) tick(mk(0, 0, 0, env_ground()), 0);
        apex_hold = dut_min_y;
        check("hold_apex_y", apex_hold, 278);
        check("hold_launch_count", start_cnt - s0, 1);
        check("hold_land_count", land_cnt - l0, 1);

        // Scenario 3: one-tick tap gives a short hop.
        dut_min_y = 1000; s0 = start_cnt;
        tick(mk(0, 0, 1, env_ground()), 0);
        for (int i = 0; i < 20; i++) tick(mk(0, 0, 0, env_ground()), 1);
        apex_tap = dut_min_y;
        check("tap_apex_y", apex_tap, 323);
        check("tap_lower_than_hold", int'(apex_tap > apex_hold), 1);
        check("tap_launch_count", start_cnt - s0, 1);

        // Scenario 4: press two ticks before ground contact.
        tick(mk_tp(100, 200), 0);
        for (int i = 0; i < 6; i++) tick(mk(0, 0, 0, 0), 0);
        s0 = start_cnt;
        tick(mk(0, 0, 1, 0), 0);
        tick(mk(0, 0, 1, 0), 0);
        tick(mk(0, 0, 1, 1), 0);
        check("buffered_launch", start_cnt - s0, 1);
        for (int i = 0; i < 40; i++) tick(mk(0, 0, 0, env_ground()), 0);

        // Scenario 5: horizontal limits and walls.
        tick(mk_tp(1, 344), 0);
        tick(mk(1, 0, 0, env_ground()), 0);
        check("left_sat_zero", int'(player_x), 0);
        tick(mk(1, 0, 0, env_ground()), 0);
        tick(mk_tp(622, 344), 0);
        tick(mk(0, 1, 0, env_ground()), 0);
        check("right_sat_max", int'(player_x), 624);
        tick(mk(0, 1, 0, env_ground()), 0);
        tick(mk(1, 1, 0, env_ground()), 0);
        check("both_hold", int'(player_x), 624);
        tick(mk_tp(300, 344), 0);
        s = mk(1, 0, 0, env_ground()); s.lw = 1;
        tick(s, 0);
        s = mk(0, 1, 0, env_ground()); s.rw = 1;
        tick(s, 0);
        check("walls_hold", int'(player_x), 300);

        // Scenario 6: jump three ticks after walking off a ledge.
        tick(mk_tp(100, 344), 0);
        tick(mk(0, 0, 0, 1), 0);
        s0 = start_cnt;
        tick(mk(0, 1, 0, 0), 0);
        tick(mk(0, 1, 0, 0), 0);
        tick(mk(0, 1, 0, 0), 0);
        tick(mk(0, 1, 1, 0), 0);
        for (int i = 0; i < 3; i++) tick(mk(0, 0, 1, 0), 0);
        check("coyote_launch", start_cnt - s0, coyote_on ? 1 : 0);
        for (int i = 0; i < 40; i++) tick(mk(0, 0, 0, env_ground()), 0);

        // Ceiling on the take-off tick, then freeze and teleport-while-frozen.
        tick(mk_tp(200, 344), 0);
        s = mk(0, 0, 1, 1); s.ceil = 1;
        tick(s, 0);
        s = mk(0, 0, 1, 0); s.ceil = 1;
        tick(s, 0);
        check("ceiling_vel_zero", int'(vel_y), 0);
        s = mk(1, 0, 1, 0); s.frz = 1;
        tick(s, 0);
        tick(s, 0);
        s = mk_tp(50, 100); s.frz = 1;
        tick(s, 0);
        check("frozen_teleport_x", int'(player_x), 50);
        for (int i = 0; i < 30; i++) tick(mk(0, 0, 0, env_ground()), 0);

        // Random ticks.
        jmp = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) jmp = !jmp;
            s = mk($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, jmp, env_ground());
            if ($urandom_range(0, 9) == 0) s.og = !s.og;
            if ($urandom_range(0, 7) == 0) s.sy = int'($urandom_range(0, 479));
            s.ceil = ($urandom_range(0, 7) == 0);
            s.lw   = ($urandom_range(0, 7) == 0);
            s.rw   = ($urandom_range(0, 7) == 0);
            s.frz  = ($urandom_range(0, 15) == 0);
            s.rp   = ($urandom_range(0, 49) == 0);
            s.rx   = int'($urandom_range(0, 624));
            s.ry   = int'($urandom_range(0, 464));
            tick(s, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
